// File: rtl/s2cif_pkg.sv
// ============================================================================
// Module      : s2cif_pkg
// Description : Shared types and constants for the scenario/circuit interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package s2cif_pkg;

    typedef logic [31:0] uint32_t;

    localparam int S2CIF_WORD_W = 32;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  cnt;
    } cap_word_t;

endpackage

`default_nettype wire

// File: rtl/mon_c2sif_fifo.sv
// ============================================================================
// Module      : mon_c2sif_fifo
// Description : Pointer-based FIFO for captured words; head is zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mon_c2sif_fifo
    import s2cif_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = cap_word_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int AW = $clog2(DEPTH);

    T             mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         wr_en;
    logic         rd_en;

    // Extra pointer MSB differs only when the write side has lapped the read side.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = empty ? T'('0) : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mon_c2sif.sv
// ============================================================================
// Module      : mon_c2sif
// Description : Serial capture monitor: packs sampled bits LSB-first into
//               words, buffers them in a FIFO, tracks overflow and bit count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mon_c2sif
    import s2cif_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    parameter int id     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              din,
    input  logic              flush,
    output logic [WORD_W-1:0] word_data,
    output logic [5:0]        word_cnt,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              ovf,
    output logic [31:0]       bit_total
);

    logic [S2CIF_WORD_W-1:0] acc_q, acc_d, acc_n;
    logic [4:0]              fill_q, fill_d;
    logic [5:0]              cnt_n;
    logic                    ovf_q, ovf_d;
    uint32_t                 bit_total_q, bit_total_d;
    logic                    full_word;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic                    fifo_full;
    logic                    fifo_empty;
    cap_word_t               push_word;
    cap_word_t               head;
    logic [31:0]             unused_id;

    assign unused_id = 32'(id);

    always_comb begin
        acc_n = acc_q;
        if (en) begin
            acc_n[fill_q] = din;
        end
        cnt_n     = {1'b0, fill_q} + 6'(en);
        full_word = en && (fill_q == 5'(WORD_W - 1));
        // A flush that coincides with a completing bit still yields one push.
        push      = full_word || (flush && (cnt_n != 6'd0));

        push_word.data = acc_n;
        push_word.cnt  = cnt_n;

        pop  = !fifo_empty && word_ready;
        drop = push && fifo_full && !pop;

        if (push) begin
            acc_d  = '0;
            fill_d = '0;
        end else begin
            acc_d  = acc_n;
            fill_d = cnt_n[4:0];
        end

        ovf_d       = ovf_q || drop;
        bit_total_d = bit_total_q + 32'(en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            fill_q      <= '0;
            ovf_q       <= 1'b0;
            bit_total_q <= '0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            ovf_q       <= ovf_d;
            bit_total_q <= bit_total_d;
        end
    end

    mon_c2sif_fifo #(
        .DEPTH (DEPTH),
        .T     (cap_word_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign word_data  = head.data[WORD_W-1:0];
    assign word_cnt   = head.cnt;
    assign word_valid = !fifo_empty;
    assign ovf        = ovf_q;
    assign bit_total  = bit_total_q;

endmodule

`default_nettype wire

// File: doc/mon_c2sif.md
# mon_c2sif

Capture-side monitor for the DFF verification environment: the return path of the scenario-to-circuit interface. It samples the DUT's serial output, packs it LSB-first into fixed-width words, and buffers complete or flushed words in a small FIFO. The scenario side drains that FIFO through a valid/ready handshake (DPI-C collector). It is instantiated next to `drv_s2cif` in the bench top, with its `din` tied to DUT `dout`.

## Interface
- `WORD_W`, 32: packed word width; legal range 2..32.
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.
- `id`, 0: instance tag, reported in debug prints only.

- `clk`  in  1  bench clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample enable; `din` is captured at each rising edge where `en` is 1.
- `din`  in  1  observed serial bit (DUT `dout`).
- `flush`  in  1  single-cycle pulse; pushes the partial word.
- `word_data`  out  `WORD_W`  FIFO head data; unused high bits are 0.
- `word_cnt`  out  6  number of valid bits in the head word, 1..`WORD_W`.
- `word_valid`  out  1  FIFO non-empty.
- `word_ready`  in  1  consumer accept.
- `ovf`  out  1  sticky overflow flag.
- `bit_total`  out  32  bits captured since reset; wraps modulo 2^32.

## Operation
- **Packer:** shift register `acc` plus bit counter `fill` (0..`WORD_W`-1). A sampled bit goes to `acc[fill]`; the first bit lands in bit 0.
- **Full word:** when `fill` = `WORD_W`-1 and a bit is sampled, push {`acc` with the new bit, cnt=`WORD_W`} and set `fill` to 0.
- **Flush:**
  - The bit sampled in the same cycle, if any, is included before the push.
  - If the resulting count is greater than 0, push {acc, cnt}, zero `acc`, and set `fill` to 0.
  - If the count is 0, nothing is pushed.
  - If the sampled bit also completes a word, exactly one push occurs (cnt=`WORD_W`).
- **Push into a full FIFO:**
  - With no pop in the same cycle, the word is dropped and `ovf` is set. `ovf` clears only on reset.
  - With a pop in the same cycle, the push is accepted.
- **Pop:** happens on any edge where `word_valid` and `word_ready` are both 1. The head advances.
- **Counter:** `bit_total` increments by 1 on every sampled bit, including bits in dropped words.
- **State:** the packer has two states, IDLE (`fill`=0) and PACKING (`fill`>0), which are implicit in `fill`. The FIFO uses wrap-around read/write pointers with one extra MSB to distinguish full from empty.

## Timing
- All outputs reset to 0: `word_data`, `word_cnt`, `word_valid`, `ovf`, `bit_total`. Reset also clears `acc`, `fill`, and both FIFO pointers.
- Reset asserted mid-word discards the partial word and all FIFO contents immediately (asynchronous).
- Push latency: a word completed or flushed at edge N shows `word_valid`=1 and its data after edge N. The consumer can pop it at edge N+1.
- `word_data` and `word_cnt` must hold stable while `word_valid`=1 and `word_ready`=0.
- Back-to-back pops sustain one word per cycle.
- `ovf` rises after the edge on which the drop occurs.
- `en` and `flush` are sampled synchronously only. There is no combinational path from any input to any output.

## Structure
- Shared package `s2cif_pkg`:
  - `uint32_t`.
  - Typedef `cap_word_t` = struct {logic [31:0] data; logic [5:0] cnt}.
  - Constant `S2CIF_WORD_W`=32.
- Sub-module `mon_c2sif_fifo`:
  - Parameterised by `DEPTH` and the `cap_word_t` payload.
  - Ports: push/pop/full/empty/head.
  - Pointer-based, registered storage.
- The top level holds the packer, the overflow logic, and `bit_total`.

## Test plan
1. Hold `word_ready`=1 and sample 32 bits alternating 1,0,1,0… → one word, data=0x55555555, cnt=32, `bit_total`=32.
2. Sample 5 bits 1,1,0,1,0, then pulse `flush` → data=0x0000000B, cnt=5. A second `flush` with no sampled bits pushes nothing.
3. Sample 31 bits of 1, then one more bit of 1 with `flush` in the same cycle → exactly one word, 0xFFFFFFFF, cnt=32. `word_valid` drops after the pop.
4. With `DEPTH`=4 and `word_ready`=0, complete 5 words → 4 held, `ovf`=1, fifth dropped. Draining returns words 1-4 in order.
5. FIFO full with `word_ready`=1 on the same edge that a fifth word completes → no drop, `ovf` stays 0, and 4 words remain after the edge.
6. Sample 10 bits, assert `rst` low for 1 cycle, then sample 32 ones → only 0xFFFFFFFF, cnt=32 emitted; `bit_total`=32.
